// File: rtl/ahb_stream_loader.sv
// ahb_stream_loader: AHB-Lite single master that fills RAM from a byte stream.
// Four stream bytes are packed little-endian into a word, then written with one
// NONSEQ transfer. Transfers never overlap. Only one transfer is outstanding at a time.
// Optional build macro STREAM_LOADER_VERIFY_EN adds a readback of every written
// word. A mismatch sets the sticky err flag.
// Without the macro, no reads are issued and err is tied low.

module ahb_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          LEN_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [31:0]      HRDATA
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ADDR,
        S_DATA,
        S_RADDR,
        S_RDATA,
        S_FIN
    } state_t;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic [31:0]      addr_reg,  addr_next;
    logic [1:0]       byte_idx_reg, byte_idx_next;
    logic [31:0]      word_packed;
    logic             byte_take;

    // A stream byte is consumed only while collecting.
    assign byte_take = (state_reg == S_COLLECT) && in_valid;

    // One byte lane per word byte. Lane k captures the k-th accepted byte of the word.
    // All lanes are rewritten before the next write, so a stale lane is never sent.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_reg;

        // Capture the byte for this lane when it arrives.
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                lane_reg <= 8'h00;
            end else if (byte_take && (byte_idx_reg == 2'(gi))) begin
                lane_reg <= in_data;
            end
        end

        assign word_packed[8*gi +: 8] = lane_reg;
    end

`ifdef STREAM_LOADER_VERIFY_EN
    logic err_reg, err_next;
`else
    // Read data has no consumer when readback is not built in.
    logic unused_hrdata;
    assign unused_hrdata = ^HRDATA;
`endif

    // State, counter, address and byte index registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            addr_reg     <= 32'h0000_0000;
            byte_idx_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            addr_reg     <= addr_next;
            byte_idx_reg <= byte_idx_next;
        end
    end

`ifdef STREAM_LOADER_VERIFY_EN
    // Sticky readback mismatch flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
`endif

    // Next-state logic.
    // At the end of a word, the address steps by 4 and the count drops by 1.
    // The address wraps naturally at 2^32.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        addr_next     = addr_reg;
        byte_idx_next = byte_idx_reg;
`ifdef STREAM_LOADER_VERIFY_EN
        err_next      = err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    count_next    = len_words;
                    addr_next     = BASE_ADDR;
                    byte_idx_next = 2'd0;
`ifdef STREAM_LOADER_VERIFY_EN
                    err_next      = 1'b0;
`endif
                    state_next    = (len_words == '0) ? S_FIN : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
`ifdef STREAM_LOADER_VERIFY_EN
                    state_next = S_RADDR;
`else
                    addr_next  = addr_reg + 32'd4;
                    count_next = count_reg - LEN_W'(1);
                    state_next = (count_reg == LEN_W'(1)) ? S_FIN : S_COLLECT;
`endif
                end
            end
`ifdef STREAM_LOADER_VERIFY_EN
            S_RADDR: begin
                if (HREADY) begin
                    state_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (HREADY) begin
                    if (HRDATA != word_packed) begin
                        err_next = 1'b1;
                    end
                    addr_next  = addr_reg + 32'd4;
                    count_next = count_reg - LEN_W'(1);
                    state_next = (count_reg == LEN_W'(1)) ? S_FIN : S_COLLECT;
                end
            end
`endif
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Bus and handshake outputs are decoded from the registered state only.
    // HADDR is held through the data phase. HWDATA is held until new bytes arrive.
    assign in_ready = (state_reg == S_COLLECT);
    assign busy     = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done     = (state_reg == S_FIN);
    assign HTRANS   = ((state_reg == S_ADDR) || (state_reg == S_RADDR)) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HWRITE   = (state_reg == S_ADDR);
    assign HSIZE    = 3'b010;
    assign HADDR    = addr_reg;
    assign HWDATA   = word_packed;
`ifdef STREAM_LOADER_VERIFY_EN
    assign err      = err_reg;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_stream_loader.sv
// Bench for ahb_stream_loader.
// The bench acts as a random-wait AHB slave backed by a word memory.
// It feeds random byte streams and checks the observed writes.
// Expected writes are BASE + 4*i carrying little-endian packed bytes.

module tb_ahb_stream_loader;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len_words = 16'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, busy, done, err;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = 32'd0;

    ahb_stream_loader #(.BASE_ADDR(BASE), .LEN_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .len_words(len_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

`ifdef STREAM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    // Slave / monitor state.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    logic [7:0]  stim_q[$];
    int          rd_cnt = 0, done_cnt = 0;
    bit          corrupt = 1'b0, directed = 1'b0;
    int          wait_pct = 0, gap_pct = 0;
    int          a_wait = 0, d_wait = 0;
    bit          dph_v = 1'b0, dph_w = 1'b0;
    logic [31:0] dph_a = 32'd0;
    bit          pa_wait = 1'b0, pd_wait = 1'b0;
    logic [31:0] pa_addr = 32'd0, pd_data = 32'd0;
    int          cyc = 0, acc_cyc = 0, a_cyc = 0, d_cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // HREADY: random waits, or a fixed 2-cycle address / 3-cycle data wait pattern.
    always @(posedge HCLK) begin
        #1;
        if (directed) begin
            if (HTRANS == 2'b10) begin
                if (a_wait < 2) begin HREADY = 1'b0; a_wait++; end
                else begin HREADY = 1'b1; a_wait = 0; end
            end else if (dph_v) begin
                if (d_wait < 3) begin HREADY = 1'b0; d_wait++; end
                else begin HREADY = 1'b1; d_wait = 0; end
            end else begin
                HREADY = 1'b1;
            end
        end else begin
            HREADY = ($urandom_range(99) >= wait_pct);
        end
    end

    // The bus monitor samples on the falling edge.
    // Values seen here are what the next rising edge will take.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dph_v = 1'b0; pa_wait = 1'b0; pd_wait = 1'b0;
        end else begin
            if (pa_wait) begin
                chk("a_hold_trans", {30'd0, HTRANS}, 32'd2);
                chk("a_hold_addr", HADDR, pa_addr);
            end
            if (pd_wait) chk("d_hold_wdata", HWDATA, pd_data);
            pa_wait = 1'b0;
            pd_wait = 1'b0;
            if (in_valid && in_ready) acc_cyc = cyc;
            if (done) done_cnt++;
            if (dph_v) begin
                if (HREADY) begin
                    if (dph_w) begin
                        wr_a_q.push_back(dph_a);
                        wr_d_q.push_back(HWDATA);
                        mem[dph_a] = HWDATA;
                        d_cyc = cyc;
                    end else begin
                        rd_cnt++;
                    end
                    dph_v = 1'b0;
                end else if (dph_w) begin
                    pd_wait = 1'b1;
                    pd_data = HWDATA;
                end
            end
            if (HTRANS == 2'b10) begin
                if (HREADY) begin
                    dph_v = 1'b1;
                    dph_a = HADDR;
                    dph_w = HWRITE;
                    if (HWRITE) a_cyc = cyc;
                    else HRDATA = (mem.exists(HADDR) ? mem[HADDR] : 32'd0) ^ {31'd0, corrupt};
                end else begin
                    pa_wait = 1'b1;
                    pa_addr = HADDR;
                end
            end
        end
    end

    // Runs one load of n words.
    // Bytes come from stim_q if the caller filled it, otherwise they are random.
    // A start pulse rides along with byte mid_byte; it must be ignored.
    task automatic run_load(input int n, input int mid_byte);
        logic [7:0]  b[$];
        logic [31:0] w;
        int g;
        if (stim_q.size() != 0) b = stim_q;
        else for (int i = 0; i < 4*n; i++) b.push_back(8'($urandom));
        stim_q.delete();
        wr_a_q.delete(); wr_d_q.delete();
        rd_cnt = 0; done_cnt = 0;
        @(posedge HCLK); #1;
        start = 1'b1; len_words = 16'(n);
        @(posedge HCLK); #1;
        start = 1'b0; len_words = 16'($urandom);
        for (int k = 0; k < 4*n; k++) begin
            while ($urandom_range(99) < gap_pct) begin @(posedge HCLK); #1; end
            in_valid = 1'b1;
            in_data  = b[k];
            if (k == mid_byte) begin start = 1'b1; len_words = 16'd7; end
            g = 0;
            do begin @(negedge HCLK); g++; end while (!in_ready && g < 500);
            if (!in_ready) begin
                chk("byte_timeout", 32'd0, 32'd1);
                in_valid = 1'b0; start = 1'b0;
                return;
            end
            @(posedge HCLK); #1;
            in_valid = 1'b0; start = 1'b0;
        end
        g = 0;
        while (done_cnt == 0 && g < 2000) begin @(negedge HCLK); g++; end
        repeat (4) @(negedge HCLK);
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        chk("wr_count", 32'(wr_a_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_a_q.size(); i++) begin
            w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            chk("wr_addr", wr_a_q[i], BASE + 32'(4*i));
            chk("wr_data", wr_d_q[i], w);
        end
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("rd_count", 32'(rd_cnt), VERIFY ? 32'(n) : 32'd0);
        chk("err_flag", {31'd0, err}, {31'd0, VERIFY & corrupt});
        $display("load n=%0d writes=%0d reads=%0d err=%0b wait=%0d gap=%0d dir=%0b",
                 n, wr_a_q.size(), rd_cnt, err, wait_pct, gap_pct, directed);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_err"},      {31'd0, err},      32'd0);
        chk({tag, "_htrans"},   {30'd0, HTRANS},   32'd0);
        chk({tag, "_hwrite"},   {31'd0, HWRITE},   32'd0);
        chk({tag, "_haddr"},    HADDR,             32'd0);
        chk({tag, "_hwdata"},   HWDATA,            32'd0);
    endtask

    initial begin
        int n;
        #12;
        chk_reset_vals("rst");
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Single word, known bytes, zero wait: latency and packing.
        wait_pct = 0; gap_pct = 0; directed = 1'b0;
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, -1);
        if (wr_d_q.size() > 0) chk("t1_word", wr_d_q[0], 32'h4433_2211);
        chk("t1_lat_addr", 32'(a_cyc), 32'(acc_cyc + 1));
        chk("t1_lat_data", 32'(d_cyc), 32'(acc_cyc + 2));
        chk("t1_hsize", {29'd0, HSIZE}, 32'd2);

        // Three words, continuous stream.
        run_load(3, -1);

        // Fixed wait states in address and data phases.
        directed = 1'b1;
        run_load(2, -1);
        directed = 1'b0;

        // Zero-length load: done the cycle after start, no bus traffic.
        wr_a_q.delete();
        @(posedge HCLK); #1;
        start = 1'b1; len_words = 16'd0;
        @(posedge HCLK); #1;
        start = 1'b0;
        @(negedge HCLK);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy", {31'd0, busy}, 32'd0);
        chk("z_htrans", {30'd0, HTRANS}, 32'd0);
        @(negedge HCLK);
        chk("z_done_off", {31'd0, done}, 32'd0);
        chk("z_no_writes", 32'(wr_a_q.size()), 32'd0);
        $display("load n=0 done_pulse checked");

        // A start pulse in the middle of a load must be ignored.
        wait_pct = 30; gap_pct = 30;
        run_load(3, 5);

        // Reset after 2 of 4 bytes, then a fresh load from BASE.
        wait_pct = 0; gap_pct = 0;
        @(posedge HCLK); #1;
        start = 1'b1; len_words = 16'd4;
        @(posedge HCLK); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + k);
            @(posedge HCLK); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        HRESETn = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        run_load(2, -1);

        // Random loads.
        for (int r = 0; r < 6; r++) begin
            wait_pct = $urandom_range(50);
            gap_pct  = $urandom_range(50);
            n = $urandom_range(5, 1);
            run_load(n, (r % 2 == 0) ? $urandom_range(4*n - 1) : -1);
        end

        // Corrupted readback sets err, which must stay set until the next start.
        wait_pct = 20; gap_pct = 10;
        corrupt = 1'b1;
        run_load(2, -1);
        repeat (5) @(negedge HCLK);
        chk("err_sticky", {31'd0, err}, {31'd0, VERIFY});
        corrupt = 1'b0;
        run_load(1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
